// File: rtl/vga_plot_pkg.sv
// ---------------------------------------------------------------------------
// vga_plot_pkg
// Shared definitions for the VGA drawing controller:
//   - command opcodes carried on cmd_op
//   - FSM state encoding of the draw engine
//   - command word layout helpers (queue entry = {op, x, y, w, h, colour})
// Optional feature macro used by the controller: VGA_PLOT_CLEAR_EN
// ---------------------------------------------------------------------------
package vga_plot_pkg;

    localparam int OP_W = 2;

    localparam logic [OP_W-1:0] OP_PIXEL = 2'b00;
    localparam logic [OP_W-1:0] OP_RECT  = 2'b01;
    localparam logic [OP_W-1:0] OP_RSVD  = 2'b10;
    localparam logic [OP_W-1:0] OP_CLEAR = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DRAW = 1'b1
    } state_t;

    // Default screen geometry (160x120, 3-bit colour)
    localparam int DEF_X_W      = 8;
    localparam int DEF_Y_W      = 7;
    localparam int DEF_COLOUR_W = 3;

    // Width of one queued command word for a given geometry
    function automatic int cmd_width(input int x_w, input int y_w, input int colour_w);
        return OP_W + 2 * x_w + 2 * y_w + colour_w;
    endfunction

    localparam int DEF_CMD_W = OP_W + 2 * DEF_X_W + 2 * DEF_Y_W + DEF_COLOUR_W;

    // Command layout at the default geometry; the controller packs the same
    // field order at its own parameterised widths.
    typedef struct packed {
        logic [OP_W-1:0]         op;
        logic [DEF_X_W-1:0]      x;
        logic [DEF_Y_W-1:0]      y;
        logic [DEF_X_W-1:0]      w;
        logic [DEF_Y_W-1:0]      h;
        logic [DEF_COLOUR_W-1:0] colour;
    } def_cmd_t;

endpackage

// File: rtl/vga_plot_ctrl_fifo.sv
// ---------------------------------------------------------------------------
// plot_fifo
// Synchronous command FIFO. Head entry is presented combinationally on dout.
// Reset clears the pointers and occupancy only; storage is left as-is.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   push, din         write request / data (ignored while full)
//   pop               read request (ignored while empty)
//   dout              head entry
//   full, empty       status flags
//   count             number of stored entries
// ---------------------------------------------------------------------------
module plot_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/vga_plot_ctrl.sv
// ---------------------------------------------------------------------------
// vga_plot_ctrl
// Drawing controller between the CPU command registers and the VGA adapter
// pixel-write port. Commands are queued in plot_fifo and expanded into one
// pixel write per clock (pixel, rectangle fill, optional clear-screen).
// Optional feature macro: VGA_PLOT_CLEAR_EN (op 11 = clear screen; when
// undefined op 11 behaves like the reserved op 10).
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   cmd_valid / cmd_ready         command handshake (ready = queue not full)
//   cmd_op, cmd_x, cmd_y          opcode and origin
//   cmd_w, cmd_h, cmd_colour      rect size and fill colour
//   vga_x, vga_y, vga_colour      pixel presented to the adapter
//   vga_plot                      write strobe, one pixel per high cycle
//   busy                          engine drawing or queue non-empty
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no command active; pops the queue head when one is present
// ST_DRAW | cursor walking the active command, one pixel per cycle
// ---------------------------------------------------------------------------
module vga_plot_ctrl
    import vga_plot_pkg::*;
#(
    parameter int X_W        = 8,
    parameter int Y_W        = 7,
    parameter int COLOUR_W   = 3,
    parameter int X_MAX      = 159,
    parameter int Y_MAX      = 119,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [X_W-1:0]      cmd_x,
    input  logic [Y_W-1:0]      cmd_y,
    input  logic [X_W-1:0]      cmd_w,
    input  logic [Y_W-1:0]      cmd_h,
    input  logic [COLOUR_W-1:0] cmd_colour,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot,
    output logic                busy
);

    localparam int CMD_W = cmd_width(X_W, Y_W, COLOUR_W);

    logic [CMD_W-1:0]            fifo_din;
    logic [CMD_W-1:0]            fifo_dout;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        fifo_push;
    logic                        fifo_pop;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    // queue head fields
    logic [1:0]          hd_op;
    logic [X_W-1:0]      hd_x;
    logic [Y_W-1:0]      hd_y;
    logic [X_W-1:0]      hd_w;
    logic [Y_W-1:0]      hd_h;
    logic [COLOUR_W-1:0] hd_colour;

    // decoded load values for the head entry
    logic [X_W-1:0]      ld_x0;
    logic [Y_W-1:0]      ld_y0;
    logic [X_W-1:0]      ld_w_last;
    logic [Y_W-1:0]      ld_h_last;
    logic                ld_op_ok;

    // active command
    state_t              state_q;
    logic [X_W-1:0]      x0_q;
    logic [Y_W-1:0]      y0_q;
    logic [X_W-1:0]      w_last_q;
    logic [Y_W-1:0]      h_last_q;
    logic [X_W-1:0]      col_q;
    logic [Y_W-1:0]      row_q;
    logic [COLOUR_W-1:0] colour_q;
    logic                op_ok_q;

    logic [X_W:0]        cur_x;
    logic [Y_W:0]        cur_y;
    logic                in_bounds;
    logic                last_pix;

    assign fifo_din  = {cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour};
    assign {hd_op, hd_x, hd_y, hd_w, hd_h, hd_colour} = fifo_dout;

    // Push uses the registered full flag, so a pop in the same cycle
    // cannot make room for a push.
    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && !fifo_full;

    plot_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Sizes are stored as last index (size-1); a zero size means one.
    always_comb begin
        ld_x0     = hd_x;
        ld_y0     = hd_y;
        ld_w_last = (hd_w == '0) ? '0 : hd_w - 1'b1;
        ld_h_last = (hd_h == '0) ? '0 : hd_h - 1'b1;
        ld_op_ok  = 1'b1;
        case (hd_op)
            OP_PIXEL: begin
                ld_w_last = '0;
                ld_h_last = '0;
            end
            OP_RECT: begin
                ld_op_ok = 1'b1;
            end
            OP_CLEAR: begin
`ifdef VGA_PLOT_CLEAR_EN
                ld_x0     = '0;
                ld_y0     = '0;
                ld_w_last = X_W'(X_MAX);
                ld_h_last = Y_W'(Y_MAX);
`else
                ld_w_last = '0;
                ld_h_last = '0;
                ld_op_ok  = 1'b0;
`endif
            end
            default: begin
                ld_w_last = '0;
                ld_h_last = '0;
                ld_op_ok  = 1'b0;
            end
        endcase
    end

    // Extra top bit keeps an off-screen cursor from aliasing onto the screen.
    assign cur_x     = {1'b0, x0_q} + {1'b0, col_q};
    assign cur_y     = {1'b0, y0_q} + {1'b0, row_q};
    assign in_bounds = (cur_x <= (X_W+1)'(X_MAX)) && (cur_y <= (Y_W+1)'(Y_MAX));
    assign last_pix  = (col_q == w_last_q) && (row_q == h_last_q);

    // Pop from IDLE, or on the final pixel so the next command follows
    // without a bubble.
    assign fifo_pop  = !fifo_empty && ((state_q == ST_IDLE) || last_pix);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            x0_q     <= '0;
            y0_q     <= '0;
            w_last_q <= '0;
            h_last_q <= '0;
            col_q    <= '0;
            row_q    <= '0;
            colour_q <= '0;
            op_ok_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fifo_pop) state_q <= ST_DRAW;
                end
                ST_DRAW: begin
                    if (last_pix) begin
                        if (!fifo_pop) state_q <= ST_IDLE;
                    end else if (col_q == w_last_q) begin
                        col_q <= '0;
                        row_q <= row_q + 1'b1;
                    end else begin
                        col_q <= col_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (fifo_pop) begin
                x0_q     <= ld_x0;
                y0_q     <= ld_y0;
                w_last_q <= ld_w_last;
                h_last_q <= ld_h_last;
                col_q    <= '0;
                row_q    <= '0;
                colour_q <= hd_colour;
                op_ok_q  <= ld_op_ok;
            end
        end
    end

    assign vga_x      = cur_x[X_W-1:0];
    assign vga_y      = cur_y[Y_W-1:0];
    assign vga_colour = colour_q;
    assign vga_plot   = (state_q == ST_DRAW) && op_ok_q && in_bounds;
    assign busy       = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule
